// File: rtl/riscv_wb_trace_if.sv
// -----------------------------------------------------------------------------
// riscv_wb_trace_if
// Bundles the signals between the core writeback stage, the trace FIFO and the
// trace consumer. clk_i/rst_ni are not part of the bundle.
//
//   Core side    : trace_en_i, flush_i, wb_valid_i, wb_rd_i, wb_value_i, wb_pc_i
//   Consumer side: trace_valid_o, trace_ready_i, trace_rd_o, trace_value_o,
//                  trace_seq_o, trace_pc_o
//   Status       : level_o (occupancy), drop_count_o (saturating drop count)
//
// Modports:
//   master - the environment (core + consumer) driving the trace unit
//   slave  - the trace unit itself
// Parameters must match those given to riscv_wb_trace.
// -----------------------------------------------------------------------------
interface riscv_wb_trace_if #(
   parameter int DEPTH = 8,
   parameter int SEQ_W = 16
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic             trace_en_i;
   logic             flush_i;
   logic             wb_valid_i;
   logic [4:0]       wb_rd_i;
   logic [31:0]      wb_value_i;
   logic [31:0]      wb_pc_i;
   logic             trace_valid_o;
   logic             trace_ready_i;
   logic [4:0]       trace_rd_o;
   logic [31:0]      trace_value_o;
   logic [SEQ_W-1:0] trace_seq_o;
   logic [31:0]      trace_pc_o;
   logic [LW-1:0]    level_o;
   logic [15:0]      drop_count_o;

   modport master (
      output trace_en_i, flush_i, wb_valid_i, wb_rd_i, wb_value_i, wb_pc_i,
      output trace_ready_i,
      input  trace_valid_o, trace_rd_o, trace_value_o, trace_seq_o, trace_pc_o,
      input  level_o, drop_count_o
   );

   modport slave (
      input  trace_en_i, flush_i, wb_valid_i, wb_rd_i, wb_value_i, wb_pc_i,
      input  trace_ready_i,
      output trace_valid_o, trace_rd_o, trace_value_o, trace_seq_o, trace_pc_o,
      output level_o, drop_count_o
   );
endinterface

// File: rtl/riscv_wb_trace.sv
// -----------------------------------------------------------------------------
// riscv_wb_trace
// Captures register-file writebacks (rd != x0, while tracing is enabled) into a
// DEPTH-entry FIFO, tagging each with a wrapping sequence number so a consumer
// can detect entries lost to a full FIFO or a flush.
//
// Ports:
//   clk_i   - single clock, rising edge
//   rst_ni  - asynchronous active-low reset
//   bus     - riscv_wb_trace_if.slave (writeback input, trace output, status)
//
// Parameters:
//   DEPTH   - FIFO entries, power of two, >= 2
//   SEQ_W   - sequence number width
//
// Build option:
//   WB_TRACE_PC_EN - when defined, each entry also stores wb_pc_i and presents
//                    it on trace_pc_o; otherwise trace_pc_o is tied to 0.
// -----------------------------------------------------------------------------
module riscv_wb_trace #(
   parameter int DEPTH = 8,
   parameter int SEQ_W = 16
) (
   input logic             clk_i,
   input logic             rst_ni,
   riscv_wb_trace_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef struct packed {
      logic [4:0]       rd;
      logic [31:0]      value;
      logic [SEQ_W-1:0] seq;
   } entry_t;

   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [SEQ_W-1:0] seq_cnt;
   logic [15:0]      drop_cnt;
   entry_t           mem [DEPTH];
   entry_t           head;

   logic capture, empty, full, pop, push, drop;

   // Pointers carry an extra wrap bit: equal means empty, differing only in the
   // wrap bit means full.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign capture = bus.trace_en_i && bus.wb_valid_i && (bus.wb_rd_i != 5'd0);
   assign pop     = !empty && bus.trace_ready_i;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push    = capture && (!full || pop);
   assign drop    = capture && full && !pop;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         seq_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         // Every capture consumes a sequence number, even if dropped or
         // flushed, so the consumer sees the gap.
         if (capture) seq_cnt <= seq_cnt + SEQ_W'(1);
         if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   // NOTE: storage has no reset; entries are only observable once the write
   // pointer has passed them, so resetting them would buy nothing.
   always_ff @(posedge clk_i) begin
      if (push && !bus.flush_i) begin
         mem[wr_ptr[AW-1:0]] <= '{rd: bus.wb_rd_i, value: bus.wb_value_i, seq: seq_cnt};
      end
   end

   assign head = mem[rd_ptr[AW-1:0]];

   assign bus.trace_valid_o = !empty;
   assign bus.trace_rd_o    = head.rd;
   assign bus.trace_value_o = head.value;
   // Sequence output is forced to 0 while empty so it reads 0 out of reset
   // even though the storage itself is never cleared.
   assign bus.trace_seq_o   = empty ? '0 : head.seq;
   assign bus.level_o       = wr_ptr - rd_ptr;
   assign bus.drop_count_o  = drop_cnt;

`ifdef WB_TRACE_PC_EN
   logic [31:0] pc_mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (push && !bus.flush_i) pc_mem[wr_ptr[AW-1:0]] <= bus.wb_pc_i;
   end

   assign bus.trace_pc_o = pc_mem[rd_ptr[AW-1:0]];
`else
   assign bus.trace_pc_o = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_wb_trace.sv
// -----------------------------------------------------------------------------
// tb_riscv_wb_trace
// Directed self-checking bench for riscv_wb_trace (DEPTH=8, SEQ_W=16).
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_riscv_wb_trace;
   localparam int DEPTH = 8;
   localparam int SEQ_W = 16;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   riscv_wb_trace_if #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) bus ();

   riscv_wb_trace #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns past the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.trace_en_i    = 1'b1;
      bus.flush_i       = 1'b0;
      bus.wb_valid_i    = 1'b0;
      bus.wb_rd_i       = 5'd0;
      bus.wb_value_i    = 32'h0;
      bus.wb_pc_i       = 32'h0;
      bus.trace_ready_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      cyc();
   endtask

   logic [31:0] exp_pc;

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      #12;
      check("reset_valid", bus.trace_valid_o, 1'b0);
      check("reset_level", bus.level_o, 0);
      check("reset_drop", bus.drop_count_o, 0);
      check("reset_seq", bus.trace_seq_o, 0);
      rst_n = 1'b1;
      cyc();

      // x5 capture then x0 write; no bypass on the capture cycle.
      bus.trace_ready_i = 1'b1;
      bus.wb_valid_i    = 1'b1;
      bus.wb_rd_i       = 5'd5;
      bus.wb_value_i    = 32'h0000_1234;
      check("nobypass_valid", bus.trace_valid_o, 1'b0);
      cyc();
      bus.wb_rd_i    = 5'd0;
      bus.wb_value_i = 32'hFFFF_FFFF;
      check("x5_valid", bus.trace_valid_o, 1'b1);
      check("x5_rd", bus.trace_rd_o, 5);
      check("x5_value", bus.trace_value_o, 32'h1234);
      check("x5_seq", bus.trace_seq_o, 0);
      cyc();
      bus.wb_valid_i = 1'b0;
      check("x0_ignored_valid", bus.trace_valid_o, 1'b0);
      check("x0_ignored_level", bus.level_o, 0);

      // Overflow: 10 captures into 8 slots with ready low.
      do_reset();
      bus.wb_valid_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.wb_rd_i    = 5'(i + 1);
         bus.wb_value_i = 32'h100 + 32'(i);
         cyc();
      end
      bus.wb_valid_i = 1'b0;
      check("ovf_level", bus.level_o, 8);
      check("ovf_drop", bus.drop_count_o, 2);
      check("ovf_head_seq", bus.trace_seq_o, 0);
      cyc();
      check("hold_seq", bus.trace_seq_o, 0);
      check("hold_rd", bus.trace_rd_o, 1);
      bus.trace_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_seq%0d", i), bus.trace_seq_o, i);
         check($sformatf("drain_rd%0d", i), bus.trace_rd_o, i + 1);
         check($sformatf("drain_val%0d", i), bus.trace_value_o, 32'h100 + i);
         cyc();
      end
      check("drained_valid", bus.trace_valid_o, 1'b0);
      bus.wb_valid_i = 1'b1;
      bus.wb_rd_i    = 5'd11;
      bus.wb_value_i = 32'h200;
      cyc();
      bus.wb_valid_i = 1'b0;
      check("after_gap_seq", bus.trace_seq_o, 10);
      cyc();
      check("after_gap_popped", bus.level_o, 0);

      // Full FIFO with simultaneous pop and capture: seq 11..18 then 19.
      bus.trace_ready_i = 1'b0;
      bus.wb_valid_i    = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.wb_rd_i    = 5'(i + 1);
         bus.wb_value_i = 32'h300 + 32'(i);
         cyc();
      end
      bus.wb_rd_i       = 5'd20;
      bus.wb_value_i    = 32'hBEEF;
      bus.trace_ready_i = 1'b1;
      check("full_level", bus.level_o, 8);
      cyc();
      bus.wb_valid_i    = 1'b0;
      bus.trace_ready_i = 1'b0;
      check("fullpop_level", bus.level_o, 8);
      check("fullpop_drop", bus.drop_count_o, 2);
      check("fullpop_head", bus.trace_seq_o, 12);
      bus.trace_ready_i = 1'b1;
      for (int i = 0; i < 7; i++) cyc();
      check("fullpop_last_seq", bus.trace_seq_o, 19);
      check("fullpop_last_rd", bus.trace_rd_o, 20);
      check("fullpop_last_val", bus.trace_value_o, 32'hBEEF);
      cyc();
      check("fullpop_empty", bus.trace_valid_o, 1'b0);

      // Flush with a simultaneous capture: seq 3 is consumed.
      do_reset();
      bus.wb_valid_i = 1'b1;
      bus.wb_rd_i    = 5'd7;
      for (int i = 0; i < 3; i++) cyc();
      bus.flush_i = 1'b1;
      check("preflush_level", bus.level_o, 3);
      cyc();
      bus.flush_i    = 1'b0;
      bus.wb_valid_i = 1'b0;
      check("flush_level", bus.level_o, 0);
      check("flush_valid", bus.trace_valid_o, 1'b0);
      check("flush_drop", bus.drop_count_o, 0);
      bus.wb_valid_i = 1'b1;
      bus.wb_rd_i    = 5'd9;
      cyc();
      bus.wb_valid_i = 1'b0;
      check("postflush_valid", bus.trace_valid_o, 1'b1);
      check("postflush_seq", bus.trace_seq_o, 4);
      bus.trace_ready_i = 1'b1;
      cyc();

      // PC capture.
      bus.trace_ready_i = 1'b0;
      bus.wb_valid_i    = 1'b1;
      bus.wb_rd_i       = 5'd1;
      bus.wb_value_i    = 32'hA5A5_A5A5;
      bus.wb_pc_i       = 32'h0000_0100;
      cyc();
      bus.wb_valid_i = 1'b0;
`ifdef WB_TRACE_PC_EN
      exp_pc = 32'h100;
`else
      exp_pc = 32'h0;
`endif
      check("pc_rd", bus.trace_rd_o, 1);
      check("pc_value", bus.trace_value_o, 32'hA5A5_A5A5);
      check("pc_seq", bus.trace_seq_o, 5);
      check("pc_pc", bus.trace_pc_o, exp_pc);

      // Asynchronous reset with 4 entries buffered and one drop recorded.
      do_reset();
      bus.wb_valid_i = 1'b1;
      bus.wb_rd_i    = 5'd3;
      for (int i = 0; i < 9; i++) cyc();
      bus.wb_valid_i    = 1'b0;
      bus.trace_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      bus.trace_ready_i = 1'b0;
      check("prereset_level", bus.level_o, 4);
      check("prereset_drop", bus.drop_count_o, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_valid", bus.trace_valid_o, 1'b0);
      check("async_drop", bus.drop_count_o, 0);
      check("async_level", bus.level_o, 0);
      check("async_seq", bus.trace_seq_o, 0);
      cyc();
      rst_n = 1'b1;
      bus.wb_valid_i = 1'b1;
      bus.wb_rd_i    = 5'd4;
      cyc();
      bus.wb_valid_i = 1'b0;
      check("post_reset_valid", bus.trace_valid_o, 1'b1);
      check("post_reset_seq", bus.trace_seq_o, 0);
      check("post_reset_rd", bus.trace_rd_o, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/riscv_wb_trace.md
RISCV_WB_TRACE -- requirements
Module: riscv_wb_trace

Interface
REQ-001 Parameter DEPTH, default 8, is the FIFO entry count; it SHALL be a power of two, minimum 2.
REQ-002 Parameter SEQ_W, default 16, is the sequence-number width.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 trace_en_i  in  1  capture enable; 0 means writebacks are ignored (not counted as drops).
REQ-006 flush_i  in  1  synchronous FIFO clear.
REQ-007 wb_valid_i  in  1  core register-file write strobe for this cycle.
REQ-008 wb_rd_i  in  5  destination register index.
REQ-009 wb_value_i  in  32  value written.
REQ-010 wb_pc_i  in  32  PC of the retiring instruction; used only under WB_TRACE_PC_EN.
REQ-011 trace_valid_o  out  1  head entry available.
REQ-012 trace_ready_i  in  1  consumer accepts the head entry.
REQ-013 trace_rd_o  out  5  head entry register index.
REQ-014 trace_value_o  out  32  head entry value.
REQ-015 trace_seq_o  out  SEQ_W  head entry sequence number.
REQ-016 trace_pc_o  out  32  head entry PC; tied 0 without WB_TRACE_PC_EN.
REQ-017 level_o  out  clog2(DEPTH)+1  current occupancy.
REQ-018 drop_count_o  out  16  saturating count of writebacks lost to a full FIFO.

Function
REQ-019 A capture event SHALL be trace_en_i=1, wb_valid_i=1 and wb_rd_i!=0; x0 writes are never captured or counted.
REQ-020 Each capture event SHALL be assigned the current sequence counter value, after which the counter increments by 1, wrapping from 2^SEQ_W-1 to 0.
REQ-021 The sequence counter SHALL increment on every capture event, including dropped ones, so consumers detect gaps.
REQ-022 A captured entry SHALL appear on trace_valid_o and the trace_* fields on the cycle after the capture edge (latency 1); outputs come from the FIFO head with no additional register stage.
REQ-023 A pop SHALL occur when trace_valid_o=1 and trace_ready_i=1; trace_* fields SHALL hold stable while trace_valid_o=1 and trace_ready_i=0.
REQ-024 When full, a capture event with no same-cycle pop SHALL be discarded and drop_count_o incremented, saturating at 16'hFFFF.
REQ-025 When full, a capture event with a same-cycle pop SHALL be accepted; level_o stays DEPTH.
REQ-026 When empty, trace_valid_o=0; a same-cycle capture is not bypassed and appears the next cycle.
REQ-027 Read/write pointers SHALL be clog2(DEPTH)+1 bits wide with wrap bit; full = pointers differ only in MSB, empty = pointers equal.
REQ-028 flush_i=1 SHALL empty the FIFO at the next edge, take priority over capture and pop in that cycle, and leave the sequence counter and drop_count_o unchanged; a capture in the flush cycle is lost but still consumes a sequence number.
REQ-029 level_o SHALL equal write pointer minus read pointer, modulo 2^(clog2(DEPTH)+1).

Reset
REQ-030 rst_ni low SHALL immediately clear pointers, sequence counter and drop_count_o, giving trace_valid_o=0, level_o=0, drop_count_o=0, trace_seq_o=0.
REQ-031 FIFO storage SHALL need no reset; trace_rd_o/trace_value_o/trace_pc_o are don't-care while trace_valid_o=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries; the first capture after release has sequence 0.

Configuration
REQ-033 With WB_TRACE_PC_EN defined, each entry SHALL store wb_pc_i and present it on trace_pc_o.
REQ-034 Without WB_TRACE_PC_EN, no PC storage SHALL be built, trace_pc_o SHALL be constant 0 and wb_pc_i SHALL be unused; all other behaviour is identical.

Verification
REQ-035 After reset, writes x5=0x0000_1234 and x0=0xFFFF_FFFF on consecutive cycles with ready=1 -> one entry rd=5, value=0x1234, seq=0, visible one cycle after capture; x0 write not seen.
REQ-036 ready=0, 10 consecutive captures with DEPTH=8 -> level_o=8, drop_count_o=2; after draining, the seq values are 0..7 and the next capture has seq=10.
REQ-037 Full FIFO, ready=1 and capture in the same cycle -> entry accepted, level_o stays 8, drop_count_o unchanged.
REQ-038 Three entries buffered, flush_i=1 together with a capture -> level_o=0 next cycle, trace_valid_o=0, the next capture carries seq=4.
REQ-039 With WB_TRACE_PC_EN, capture x1=0xA5A5A5A5 at pc=0x0000_0100 -> trace_pc_o=0x100; without the macro trace_pc_o=0.
REQ-040 rst_ni asserted asynchronously between edges with 4 entries buffered -> trace_valid_o and drop_count_o are 0 before the next clock edge; the first capture after release has seq=0.
